read_order_buffer: RTL
======================

# read_order_buffer

Read-channel counterpart of the write-ordering path. The block sits between the masters' AXI read address/data channels and the slaves, with the slaves allowed to return single-beat reads in any order. Each accepted AR is tagged with a reorder slot index on `m_aruser`, and the slave echoes that index on `m_ruser`. Returned beats are parked in their slot and released to the master strictly in AR acceptance order.

## Interface
Parameters:
- ID_W, 4, width of arid/rid
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- DEPTH, 4, reorder slots (power of 2, ≥2)
- TAG_W, $clog2(DEPTH), slot tag width (derived, not overridable)

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- s_arvalid  in  1  AR valid from master
- s_arready  out  1  AR ready to master
- s_arid  in  ID_W  AR id
- s_araddr  in  ADDR_W  AR address
- s_rvalid  out  1  R valid to master
- s_rready  in  1  R ready from master
- s_rid  out  ID_W  R id (the stored arid)
- s_rdata  out  DATA_W  R data
- s_rresp  out  2  R response
- s_rlast  out  1  constant 1
- m_arvalid  out  1  AR valid to slave
- m_arready  in  1  AR ready from slave
- m_arid, m_araddr  out  ID_W, ADDR_W  pass-through of s_arid, s_araddr
- m_arlen  out  8  constant 0 (single beat only)
- m_aruser  out  TAG_W  slot tag (tail index)
- m_rvalid  in  1  R valid from slave
- m_rready  out  1  constant 1
- m_rdata, m_rresp  in  DATA_W, 2  R payload from slave
- m_ruser  in  TAG_W  echoed slot tag
- occupancy  out  TAG_W+1  allocated slot count
- tag_err  out  1  sticky protocol-error flag

## Operation
Per-slot state:
- `alloc`, `filled`, `id`, `data`, `resp`.
- `head` and `tail` pointers, TAG_W bits, wrapping modulo DEPTH.
- `count` register, 0..DEPTH.

AR path (combinational):
- `full = (count == DEPTH)`, computed from the registered count.
- `m_arvalid = s_arvalid & ~full`; `s_arready = m_arready & ~full`.
- `m_aruser = tail`.

AR accept (`s_arvalid & s_arready`):
- `alloc[tail] <= 1`, `filled[tail] <= 0`, `id[tail] <= s_arid`.
- `tail` advances by 1.

R capture (`m_rvalid`, always accepted):
- If `alloc[m_ruser] & ~filled[m_ruser]`: store `data` and `resp`, set `filled`.
- Otherwise, i.e. the slot is unallocated or already filled: drop the beat, leave slot state unchanged, set `tag_err <= 1`. `tag_err` clears only on reset.

Release:
- `s_rvalid = alloc[head] & filled[head]`.
- `s_rid`, `s_rdata`, `s_rresp` come from slot `head`.
- On `s_rvalid & s_rready`: clear `alloc[head]` and `filled[head]`; `head` advances by 1.
- Payload stays stable while `s_rvalid & ~s_rready`.

Count update:
- Accept only: +1.
- Release only: −1.
- Both in the same cycle: unchanged.
- `occupancy = count`.

## Timing
- AR: zero-cycle combinational pass-through. The slot is allocated at the clock edge of the handshake.
- R: a beat captured at edge N can drive `s_rvalid` from cycle N+1 if its slot is head. There is no same-cycle bypass.
- In-order return latency is therefore 1 cycle.
- A beat for a non-head slot waits until every older slot has been released.

Full:
- AR is blocked while `count == DEPTH`, even if a release happens in the same cycle. The freed slot becomes allocatable the next cycle.

Empty:
- `s_rvalid = 0`. A capture into a slot (with `head == tail`, `count == 0`) cannot occur legally and raises `tag_err`.

Simultaneous events:
- Capture into slot k≠head plus release of head in the same cycle: both take effect.
- Accept into tail plus capture into another slot: both take effect.
- Release of slot j plus an accept that reuses slot j in the same cycle is impossible, since it needs `full`, which blocks the accept.

Reset values (immediate on `rst`, mid-operation included):
- `s_rvalid = 0`, `tag_err = 0`, `occupancy = 0`.
- `head = tail = 0`; all `alloc` and `filled` cleared.
- Outstanding reads are discarded.
- `s_arready` and `m_arvalid` then follow the combinational equations with `count = 0`.

## Test plan
- **In-order return.** Issue ARs with ids 1,2,3; slave returns tags 0,1,2 with data A1,A2,A3.
  - `m_aruser` = 0,1,2.
  - Master receives (rid,data) = (1,A1),(2,A2),(3,A3), each one cycle after capture.
- **Reverse return.** Issue 4 ARs with DEPTH=4; slave returns tags 3,2,1,0.
  - `s_rvalid` stays 0 until tag 0 is captured.
  - Then 4 consecutive beats come out in tag order 0..3 with `s_rready = 1`.
- **Full backpressure.** Issue 4 ARs with no returns, then assert a 5th `s_arvalid`.
  - `s_arready = 0`, `m_arvalid = 0`, `occupancy = 4`.
  - Return and release tag 0: the 5th AR is accepted the following cycle with `m_aruser = 0`.
- **Master stall.** Hold `s_rready = 0` for 5 cycles with head filled.
  - `s_rvalid`, `s_rid` and `s_rdata` are held constant.
  - Meanwhile tag 2 is captured and `tag_err` stays 0.
- **Protocol error.** Send an R beat with `m_ruser = 2` when only slots 0–1 are allocated, then a second beat to the already-filled slot 0.
  - `tag_err` rises and stays 1.
  - Slot contents and release order are unchanged.
- **Reset mid-operation.** Assert `rst` with 3 slots outstanding and one beat pending on `s_rvalid`.
  - All outputs return to their reset values immediately.
  - After deassert, a new AR gets `m_aruser = 0`.

Source files
------------

// File: rtl/read_order_buffer.sv
// Read reorder buffer: tags each AR with a slot index, parks out-of-order
// single-beat R responses in their slot and releases them in AR order.
module read_order_buffer #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  // Master-side AR
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  // Master-side R
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  // Slave-side AR
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [TAG_W-1:0]  m_aruser,
  // Slave-side R
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic [TAG_W-1:0]  m_ruser,
  // Status
  output logic [TAG_W:0]    occupancy,
  output logic              tag_err
);

  localparam int unsigned CntW = TAG_W + 1;

  logic [DEPTH-1:0]  alloc_q, alloc_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [ID_W-1:0]   id_q   [DEPTH];
  logic [ID_W-1:0]   id_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [1:0]        resp_q [DEPTH];
  logic [1:0]        resp_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              tag_err_q, tag_err_d;

  logic full;
  logic acc;
  logic rel;
  logic cap_ok;

  // Handshake decode and fixed-value outputs
  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    m_arvalid = s_arvalid & ~full;
    s_arready = m_arready & ~full;
    m_arid    = s_arid;
    m_araddr  = s_araddr;
    m_arlen   = 8'd0;
    m_aruser  = tail_q;
    m_rready  = 1'b1;
    acc       = s_arvalid & s_arready;
    s_rvalid  = alloc_q[head_q] & filled_q[head_q];
    s_rid     = id_q[head_q];
    s_rdata   = data_q[head_q];
    s_rresp   = resp_q[head_q];
    s_rlast   = 1'b1;
    rel       = s_rvalid & s_rready;
    // A beat is only legal for an allocated slot still waiting for data
    cap_ok    = alloc_q[m_ruser] & ~filled_q[m_ruser];
    occupancy = count_q;
    tag_err   = tag_err_q;
  end

  // Next-state for slot bookkeeping, pointers, count and error flag
  always_comb begin
    alloc_d   = alloc_q;
    filled_d  = filled_q;
    id_d      = id_q;
    data_d    = data_q;
    resp_d    = resp_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    tag_err_d = tag_err_q;

    if (rel) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + TAG_W'(1);
    end

    // Accept never hits the head slot being released: that would require full
    if (acc) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      id_d[tail_q]     = s_arid;
      tail_d           = tail_q + TAG_W'(1);
    end

    if (m_rvalid) begin
      if (cap_ok) begin
        filled_d[m_ruser] = 1'b1;
        data_d[m_ruser]   = m_rdata;
        resp_d[m_ruser]   = m_rresp;
      end else begin
        tag_err_d = 1'b1;
      end
    end

    unique case ({acc, rel})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all outstanding reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q   <= '0;
      filled_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      filled_q  <= filled_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      tag_err_q <= tag_err_d;
    end
  end

  // Slot payload; only meaningful while the slot's alloc/filled bits say so
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    data_q <= data_d;
    resp_q <= resp_d;
  end

endmodule
